unary_unit_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one unary bitstream unit (e.g. the unary multiply-by-two) between NUM_REQ requesters.
- Grants one requester at a time and streams its INPUT_WIDTH input bits into the unit.
- Routes the unit's INPUT_WIDTH output bits back to that requester, then pulses the unit's reset so it is clean for the next job.
- Sits between the requester bitstream sources and the shared unit instance.

---
 rtl/unary_unit_rr_scheduler_if.sv | 32 +++
 rtl/unary_unit_rr_scheduler.sv | 130 +++++++++++++
 tb/tb_unary_unit_rr_scheduler.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/unary_unit_rr_scheduler_if.sv
// Handshake bundle between the requester sources, the round-robin scheduler
// and the shared unary bitstream unit.
interface unary_unit_rr_scheduler_if #(
   parameter int NUM_REQ = 4
);
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] req_bit;
   logic [NUM_REQ-1:0] req_bit_valid;
   logic [NUM_REQ-1:0] req_bit_ready;
   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] rsp_valid;
   logic [NUM_REQ-1:0] done;
   logic               busy;
   logic               unit_a;
   logic               unit_ready;
   logic               unit_y;
   logic               unit_valid;
   logic               unit_rst_n;
   logic               rsp_bit;

   modport master (
      input  req, req_bit, req_bit_valid, unit_y, unit_valid,
      output req_bit_ready, grant, busy, unit_a, unit_ready, unit_rst_n,
             rsp_bit, rsp_valid, done
   );

   modport slave (
      output req, req_bit, req_bit_valid, unit_y, unit_valid,
      input  req_bit_ready, grant, busy, unit_a, unit_ready, unit_rst_n,
             rsp_bit, rsp_valid, done
   );
endinterface

// File: rtl/unary_unit_rr_scheduler.sv
// Round-robin owner of one shared unary bitstream unit: streams a job in, routes
// results back, then resets the unit. UNARY_SCHED_TIMEOUT_EN adds a stall watchdog.
module unary_unit_rr_scheduler #(
   parameter int NUM_REQ        = 4,
   parameter int INPUT_WIDTH    = 32,
   parameter int COUNT_WIDTH    = $clog2(INPUT_WIDTH + 1),
   parameter int IDX_WIDTH      = $clog2(NUM_REQ),
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic reset,
   unary_unit_rr_scheduler_if.master bus
`ifdef UNARY_SCHED_TIMEOUT_EN
   ,
   output logic timeout_err
`endif
);
   typedef enum logic [1:0] {IDLE, STREAM, DRAIN, CLEAR} state_t;

   localparam logic [COUNT_WIDTH-1:0] FULL = COUNT_WIDTH'(INPUT_WIDTH);

   if (NUM_REQ < 2 || INPUT_WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("unary_unit_rr_scheduler: illegal parameterisation");
   end

   state_t                 state, state_n;
   logic [NUM_REQ-1:0]     grant, done_q;
   logic [IDX_WIDTH-1:0]   idx, last_grant, pick_idx;
   logic [COUNT_WIDTH-1:0] in_cnt, out_cnt, in_cnt_n, out_cnt_n;
   logic                   pick_found, unit_rst_q;
   logic                   in_phase, in_open, take, fire_in, fire_out, wd_hit;

   // first pending request after the previous owner, wrapping
   always_comb begin
      int j;
      j          = 0;
      pick_found = 1'b0;
      pick_idx   = '0;
      for (int i = 1; i <= NUM_REQ; i++) begin
         j = (int'(last_grant) + i) % NUM_REQ;
         if (!pick_found && bus.req[j]) begin
            pick_found = 1'b1;
            pick_idx   = IDX_WIDTH'(j);
         end
      end
   end

   assign in_phase  = (state == STREAM) || (state == DRAIN);
   assign in_open   = in_cnt < FULL;
   assign take      = in_phase && in_open && bus.req_bit_valid[idx];
   assign fire_in   = (state == STREAM) && in_open && bus.req_bit_valid[idx];
   assign fire_out  = (state == STREAM) && bus.unit_valid && (out_cnt < FULL);
   assign in_cnt_n  = in_cnt + COUNT_WIDTH'(take);
   assign out_cnt_n = out_cnt + COUNT_WIDTH'(fire_out);

   assign bus.req_bit_ready = (in_phase && in_open) ? grant : '0;
   assign bus.unit_ready    = fire_in;
   assign bus.unit_a        = fire_in && bus.req_bit[idx];
   assign bus.rsp_valid     = fire_out ? grant : '0;
   assign bus.rsp_bit       = fire_out && bus.unit_y;
   assign bus.grant         = grant;
   assign bus.done          = done_q;
   assign bus.busy          = (state != IDLE);
   assign bus.unit_rst_n    = unit_rst_q;

`ifdef UNARY_SCHED_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WD_W-1:0] wd_cnt;

   // any movement on either side of the unit counts as progress
   assign wd_hit      = in_phase && !(bus.unit_valid || fire_in) &&
                        (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
   assign timeout_err = wd_hit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                wd_cnt <= '0;
      else if (!in_phase || bus.unit_valid || fire_in) wd_cnt <= '0;
      else                                       wd_cnt <= wd_cnt + WD_W'(1);
   end
`else
   assign wd_hit = 1'b0;
`endif

   always_comb begin
      state_n = state;
      case (state)
         IDLE:   if (pick_found) state_n = STREAM;
         STREAM: if (out_cnt_n == FULL) state_n = (in_cnt_n == FULL) ? CLEAR : DRAIN;
         DRAIN:  if (in_cnt_n == FULL) state_n = CLEAR;
         CLEAR:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
      if (wd_hit) state_n = CLEAR;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         grant      <= '0;
         idx        <= '0;
         last_grant <= IDX_WIDTH'(NUM_REQ - 1);
         in_cnt     <= '0;
         out_cnt    <= '0;
         done_q     <= '0;
         unit_rst_q <= 1'b0;
      end else begin
         state      <= state_n;
         // done and the unit reset both line up with the CLEAR cycle
         done_q     <= (state_n == CLEAR) ? grant : '0;
         unit_rst_q <= (state_n != CLEAR);
         case (state)
            IDLE: if (pick_found) begin
               grant   <= NUM_REQ'(1) << pick_idx;
               idx     <= pick_idx;
               in_cnt  <= '0;
               out_cnt <= '0;
            end
            STREAM, DRAIN: begin
               in_cnt  <= in_cnt_n;
               out_cnt <= out_cnt_n;
            end
            CLEAR: begin
               grant      <= '0;
               last_grant <= idx;
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_unary_unit_rr_scheduler.sv
// Directed bench for unary_unit_rr_scheduler: single job, round robin, input
// stall with drain, reset mid-stream, and (with the macro) the watchdog.
module tb_unary_unit_rr_scheduler;
   localparam int NR = 4;
   localparam int W  = 8;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   unary_unit_rr_scheduler_if #(.NUM_REQ(NR)) u ();

`ifdef UNARY_SCHED_TIMEOUT_EN
   logic te;
`endif

   unary_unit_rr_scheduler #(
      .NUM_REQ(NR), .INPUT_WIDTH(W), .TIMEOUT_CYCLES(16)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(u)
`ifdef UNARY_SCHED_TIMEOUT_EN
      ,
      .timeout_err(te)
`endif
   );

   // unary x2 unit model: a 1 is echoed and owed once more, owed 1s fill zeros
   logic m_valid, m_y;
   int   m_pend;
   always @(posedge clk or negedge u.unit_rst_n) begin
      if (!u.unit_rst_n) begin
         m_valid <= 1'b0; m_y <= 1'b0; m_pend <= 0;
      end else begin
         m_valid <= u.unit_ready;
         if (u.unit_ready) begin
            if (u.unit_a) begin m_y <= 1'b1; m_pend <= m_pend + 1; end
            else if (m_pend > 0) begin m_y <= 1'b1; m_pend <= m_pend - 1; end
            else m_y <= 1'b0;
         end
      end
   end

   logic force_unit, force_valid, force_y;
   assign u.unit_valid = force_unit ? force_valid : m_valid;
   assign u.unit_y     = force_unit ? force_y : m_y;

   int total = 0, bad = 0, cyc = 0;
   logic [W-1:0]  src_data [NR];
   int            src_ptr  [NR];
   int            done_ptr [NR];
   int            rsp_cnt  [NR];
   logic [W-1:0]  rsp_word [NR];
   logic [NR-1:0] src_en, stall, prev_grant;
   bit            phase, hold;
   logic [NR-1:0] grant_seq[$], done_seq[$];
   int            grant_cyc[$], done_cyc[$], to_cyc[$];
   int            n_ready, n_drain, ready_bad, onehot_bad, rst_bad;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic clear_logs();
      grant_seq.delete(); done_seq.delete();
      grant_cyc.delete(); done_cyc.delete(); to_cyc.delete();
      n_ready = 0; n_drain = 0; ready_bad = 0; onehot_bad = 0; rst_bad = 0;
      prev_grant = '0;
      for (int i = 0; i < NR; i++) begin rsp_cnt[i] = 0; rsp_word[i] = '0; done_ptr[i] = 0; end
   endtask

   // one cycle: drive at negedge, sample 1ns later, account consumption at posedge
   task automatic tick();
      logic [NR-1:0] tk, dn;
      for (int i = 0; i < NR; i++) begin
         u.req_bit[i]       = src_data[i][src_ptr[i] % W];
         u.req_bit_valid[i] = src_en[i] && (src_ptr[i] < W) && (!stall[i] || phase);
      end
      #1;
      if ($countones(u.grant) > 1 || $countones(u.rsp_valid) > 1 ||
          $countones(u.done) > 1 || $countones(u.req_bit_ready) > 1) onehot_bad++;
      if (u.grant != '0 && u.grant != prev_grant) begin
         grant_seq.push_back(u.grant); grant_cyc.push_back(cyc);
      end
      prev_grant = u.grant;
      if (u.unit_ready) begin
         n_ready++;
         if ((u.req_bit_valid & u.grant) == '0) ready_bad++;
      end
      if (u.busy && (u.req_bit_ready & u.req_bit_valid) != '0 && !u.unit_ready) n_drain++;
      for (int i = 0; i < NR; i++)
         if (u.rsp_valid[i]) begin
            if (rsp_cnt[i] < W) rsp_word[i][rsp_cnt[i]] = u.rsp_bit;
            rsp_cnt[i]++;
         end
`ifdef UNARY_SCHED_TIMEOUT_EN
      if (te) to_cyc.push_back(cyc);
`endif
      dn = u.done;
      if (dn != '0) begin
         done_seq.push_back(dn); done_cyc.push_back(cyc);
         if (u.unit_rst_n !== 1'b0) rst_bad++;
      end
      tk = u.req_bit_ready & u.req_bit_valid;
      @(posedge clk);
      for (int i = 0; i < NR; i++) begin
         if (tk[i]) src_ptr[i]++;
         if (dn[i]) begin
            done_ptr[i] = src_ptr[i]; src_ptr[i] = 0;
            if (!hold) u.req[i] = 1'b0;
         end
      end
      @(negedge clk);
      phase = !phase;
      cyc++;
   endtask

   task automatic wait_done(input string tag, input int n, input int budget);
      for (int k = 0; k < budget && done_seq.size() < n; k++) tick();
      chk(tag, done_seq.size(), n);
   endtask

   task automatic do_reset(input logic [NR-1:0] req_at_release);
      reset = 1'b0;
      u.req = '0; u.req_bit = '0; u.req_bit_valid = '0;
      force_unit = 1'b0; force_valid = 1'b0; force_y = 1'b0;
      src_en = '0; stall = '0; hold = 1'b0; phase = 1'b0;
      for (int i = 0; i < NR; i++) begin src_ptr[i] = 0; src_data[i] = '0; end
      repeat (2) @(negedge clk);
      u.req = req_at_release;
      reset = 1'b1;
   endtask

   initial begin
      int c0;
      clear_logs();
      do_reset('0);
      reset = 1'b0;
      #1;
      // reset state
      chk("rst_grant", u.grant, 0);
      chk("rst_busy", u.busy, 0);
      chk("rst_unit_rst_n", u.unit_rst_n, 0);
      chk("rst_done", u.done, 0);
      chk("rst_ready", {u.req_bit_ready, u.unit_ready, u.unit_a}, 0);
      chk("rst_rsp", {u.rsp_valid, u.rsp_bit}, 0);
      @(negedge clk);

      // single job on requester 1
      do_reset('0);
      clear_logs();
      src_data[1] = 8'b0000_0011; src_en[1] = 1'b1;
      u.req = 4'b0010;
      c0 = cyc;
      wait_done("t1_done_seen", 1, 40);
      chk("t1_grant_val", grant_seq.size() > 0 ? grant_seq[0] : 0, 4'b0010);
      chk("t1_grant_lat", grant_cyc.size() > 0 ? grant_cyc[0] - c0 : -1, 1);
      chk("t1_unit_ready_cycles", n_ready, 8);
      chk("t1_rsp_cnt", rsp_cnt[1], 8);
      chk("t1_rsp_word", rsp_word[1], 8'b0000_1111);
      chk("t1_done_val", done_seq.size() > 0 ? done_seq[0] : 0, 4'b0010);
      chk("t1_done_lat", (done_cyc.size() > 0 && grant_cyc.size() > 0) ?
                         done_cyc[0] - grant_cyc[0] : -1, 9);
      chk("t1_done_unit_rst", rst_bad, 0);
      tick();
      chk("t1_grant_cleared", u.grant, 0);
      chk("t1_done_once", done_seq.size(), 1);

      // round robin with 0,1,3 held from reset
      do_reset(4'b1011);
      clear_logs();
      hold = 1'b1;
      for (int i = 0; i < NR; i++) begin src_data[i] = 8'b1010_0101; src_en[i] = 1'b1; end
      wait_done("t2_six_jobs", 6, 200);
      for (int k = 0; k < 6; k++) begin
         logic [NR-1:0] exp_g;
         exp_g = (k % 3 == 0) ? 4'b0001 : (k % 3 == 1) ? 4'b0010 : 4'b1000;
         chk($sformatf("t2_grant%0d", k), grant_seq.size() > k ? grant_seq[k] : 0, exp_g);
      end
      for (int k = 0; k < 5; k++)
         chk($sformatf("t2_turnaround%0d", k),
             (grant_cyc.size() > k + 1 && done_cyc.size() > k) ?
             grant_cyc[k+1] - done_cyc[k] : -1, 2);
      chk("t2_onehot", onehot_bad, 0);

      // alternating input valid on requester 2; a forced unit finishes early
      do_reset('0);
      clear_logs();
      src_data[2] = 8'hA5; src_en[2] = 1'b1; stall[2] = 1'b1;
      force_unit = 1'b1; force_valid = 1'b1; force_y = 1'b1;
      u.req = 4'b0100;
      phase = 1'b1;
      wait_done("t3_done_seen", 1, 60);
      chk("t3_unit_ready_cycles", n_ready, 4);
      chk("t3_ready_without_valid", ready_bad, 0);
      chk("t3_drain_consumed", n_drain, 4);
      chk("t3_bits_consumed", done_ptr[2], 8);
      chk("t3_rsp_cnt", rsp_cnt[2], 8);
      chk("t3_rsp_word", rsp_word[2], 8'hFF);
      chk("t3_done_val", done_seq.size() > 0 ? done_seq[0] : 0, 4'b0100);
      force_unit = 1'b0;

      // reset while requester 2 is mid-stream
      do_reset('0);
      clear_logs();
      src_data[2] = 8'h3C; src_en[2] = 1'b1;
      u.req = 4'b0100;
      for (int k = 0; k < 10 && src_ptr[2] < 3; k++) tick();
      chk("t4_in_cnt_at_reset", src_ptr[2], 3);
      reset = 1'b0;
      #1;
      chk("t4_grant", u.grant, 0);
      chk("t4_busy", u.busy, 0);
      chk("t4_unit_rst_n", u.unit_rst_n, 0);
      chk("t4_comb_outs", {u.req_bit_ready, u.unit_ready, u.rsp_valid, u.done}, 0);
      chk("t4_no_done", done_seq.size(), 0);
      @(negedge clk);
      clear_logs();
      for (int i = 0; i < NR; i++) begin src_ptr[i] = 0; src_en[i] = 1'b1; end
      u.req = 4'b1111;
      reset = 1'b1;
      for (int k = 0; k < 4 && grant_seq.size() == 0; k++) tick();
      chk("t4_regrant", grant_seq.size() > 0 ? grant_seq[0] : 0, 4'b0001);

`ifdef UNARY_SCHED_TIMEOUT_EN
      // stalled job on requester 1 is aborted by the watchdog
      do_reset('0);
      clear_logs();
      force_unit = 1'b1; force_valid = 1'b0;
      u.req = 4'b0010;
      wait_done("t5_done_seen", 1, 60);
      chk("t5_timeout_pulses", to_cyc.size(), 1);
      chk("t5_timeout_at", (to_cyc.size() > 0 && grant_cyc.size() > 0) ?
                           to_cyc[0] - grant_cyc[0] : -1, 15);
      chk("t5_clear_after", (to_cyc.size() > 0 && done_cyc.size() > 0) ?
                            done_cyc[0] - to_cyc[0] : -1, 1);
      chk("t5_done_unit_rst", rst_bad, 0);
      force_unit = 1'b0;
      clear_logs();
      src_data[1] = 8'b0000_0011; src_en[1] = 1'b1;
      u.req = 4'b0010;
      wait_done("t5_next_done", 1, 40);
      chk("t5_next_rsp", rsp_word[1], 8'b0000_1111);
      chk("t5_next_cnt", rsp_cnt[1], 8);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
